// File: rtl/signal_sequencer.sv
// Control-word sequencer: fetches words from a registered ROM and presents each for hold+1 accepted beats.
// Optional build macro SEQ_LOOP_EN makes the sequence wrap to address 0 until stop_i is seen.
module signal_sequencer #(
  parameter int MEMORY_WIDTH = 63,
  parameter int ADDRS_WIDTH  = 4,
  parameter int HOLD_WIDTH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [ADDRS_WIDTH-1:0]  last_addrs_i,
  input  logic [HOLD_WIDTH-1:0]   hold_cycles_i,
  output logic [ADDRS_WIDTH-1:0]  addrs_rom_signal_o,
  output logic                    rd_rom_signals_ld_o,
  input  logic [MEMORY_WIDTH-1:0] rom_signals_data_i,
  output logic [MEMORY_WIDTH-1:0] ctrl_data_o,
  output logic                    ctrl_valid_o,
  input  logic                    ctrl_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [2:0]              state_o
);

  // ctrl_valid_o/ctrl_ready_i: a beat transfers on every rising edge where both are high;
  // while valid is high and ready is low, ctrl_data_o and all sequencer state stay frozen.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRS_WIDTH-1:0]  addr_q;
  logic [ADDRS_WIDTH-1:0]  last_q;
  logic [HOLD_WIDTH-1:0]   hold_q;
  logic [HOLD_WIDTH-1:0]   beat_q;
  logic                    stop_q;
  logic [MEMORY_WIDTH-1:0] data_q;

  logic last_beat;
  logic stop_eff;
  logic at_last;

  // beat_q only counts up to hold_q, so it never needs a wider counter.
  assign last_beat = (state_q == S_PRESENT) && ctrl_ready_i && (beat_q == hold_q);
  assign stop_eff  = stop_q | stop_i;
  assign at_last   = (addr_q == last_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_FETCH;
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_PRESENT;
      S_PRESENT: begin
        if (last_beat) begin
`ifdef SEQ_LOOP_EN
          if (stop_eff) state_d = S_DONE;
          else          state_d = S_FETCH;
`else
          if (stop_eff || at_last) state_d = S_DONE;
          else                     state_d = S_FETCH;
`endif
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      last_q <= '0;
      hold_q <= '0;
      beat_q <= '0;
      stop_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        addr_q <= '0;
        last_q <= last_addrs_i;
        hold_q <= hold_cycles_i;
        stop_q <= 1'b0;
      end else if (state_q != S_IDLE && stop_i) begin
        stop_q <= 1'b1;
      end
      if (state_q == S_CAPTURE) begin
        data_q <= rom_signals_data_i;
        beat_q <= '0;
      end
      if (state_q == S_PRESENT && ctrl_ready_i && !last_beat) begin
        beat_q <= beat_q + HOLD_WIDTH'(1);
      end
      // Leaving PRESENT for FETCH while at_last only happens in loop builds: wrap to 0.
      if (last_beat && state_d == S_FETCH) begin
        addr_q <= at_last ? '0 : addr_q + ADDRS_WIDTH'(1);
      end
      if (state_d == S_DONE) begin
        data_q <= '0;
      end
    end
  end

  always_comb begin
    rd_rom_signals_ld_o = 1'b0;
    ctrl_valid_o        = 1'b0;
    busy_o              = 1'b0;
    done_o              = 1'b0;
    case (state_q)
      S_FETCH:   rd_rom_signals_ld_o = 1'b1;
      S_PRESENT: ctrl_valid_o        = 1'b1;
      S_DONE:    done_o              = 1'b1;
      default:   ;
    endcase
    busy_o = (state_q != S_IDLE);
  end

  assign addrs_rom_signal_o = addr_q;
  assign ctrl_data_o        = data_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_signal_sequencer.sv
// Self-checking bench for signal_sequencer: ROM model, beat scoreboard, scenario tasks.
module tb_signal_sequencer;

  localparam int MW = 63;
  localparam int AW = 4;
  localparam int HW = 8;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] last_addrs = '0;
  logic [HW-1:0] hold_cycles = '0;
  logic [AW-1:0] addrs;
  logic          rd;
  logic [MW-1:0] rom_data = '0;
  logic [MW-1:0] ctrl_data;
  logic          ctrl_valid;
  logic          ctrl_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [2:0]    state;

  logic [MW-1:0] rom [16];
  logic [MW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  int valid_cycles = 0;
  int beats = 0;
  int ready_mode = 0;
  logic          prev_stall = 1'b0;
  logic [MW-1:0] prev_data = '0;

  signal_sequencer #(.MEMORY_WIDTH(MW), .ADDRS_WIDTH(AW), .HOLD_WIDTH(HW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .last_addrs_i(last_addrs), .hold_cycles_i(hold_cycles),
    .addrs_rom_signal_o(addrs), .rd_rom_signals_ld_o(rd),
    .rom_signals_data_i(rom_data), .ctrl_data_o(ctrl_data),
    .ctrl_valid_o(ctrl_valid), .ctrl_ready_i(ctrl_ready),
    .busy_o(busy), .done_o(done), .state_o(state)
  );

  // Clock and registered ROM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd) rom_data <= rom[addrs];
  end

  // Scoreboard: fetch addresses and accepted beats are popped against expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          $display("FAIL fetch_addr: unexpected fetch of addr %0d, none expected", addrs);
        end else begin
          logic [AW-1:0] ea;
          ea = exp_addr_q.pop_front();
          if (addrs !== ea) $display("FAIL fetch_addr: got %0d expected %0d", addrs, ea);
          else passes++;
        end
      end
      if (ctrl_valid) begin
        valid_cycles++;
        if (prev_stall) begin
          checks++;
          if (ctrl_data !== prev_data) $display("FAIL stall_stable: got %0h expected %0h", ctrl_data, prev_data);
          else passes++;
        end
        if (ctrl_ready) begin
          beats++;
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL beat_data: unexpected beat %0h, none expected", ctrl_data);
          end else begin
            logic [MW-1:0] ed;
            ed = exp_q.pop_front();
            if (ctrl_data !== ed) $display("FAIL beat_data: got %0h expected %0h", ctrl_data, ed);
            else passes++;
          end
        end
      end
      prev_stall = ctrl_valid && !ctrl_ready;
      prev_data  = ctrl_data;
      if (done) done_cnt++;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      1:       ctrl_ready = ~ctrl_ready;
      2:       ctrl_ready = 1'($urandom_range(0, 1));
      default: ctrl_ready = 1'b1;
    endcase
  endtask

  task automatic clear_stats();
    done_cnt = 0;
    valid_cycles = 0;
    beats = 0;
  endtask

  task automatic push_seq(input int last, input int hold);
    for (int a = 0; a <= last; a++) begin
      exp_addr_q.push_back(AW'(a));
      for (int b = 0; b <= hold; b++) exp_q.push_back(rom[a]);
    end
  endtask

  task automatic start_seq(input int last, input int hold);
    start = 1'b1;
    last_addrs = AW'(last);
    hold_cycles = HW'(hold);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      step();
      cyc++;
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else passes++;
    checks++; if (rd !== 1'b0) $display("FAIL reset_rd: got %0b expected 0", rd); else passes++;
    checks++; if (ctrl_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", ctrl_valid); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else passes++;
    checks++; if (ctrl_data !== '0) $display("FAIL reset_data: got %0h expected 0", ctrl_data); else passes++;
    checks++; if (addrs !== '0) $display("FAIL reset_addr: got %0d expected 0", addrs); else passes++;
    rst = 1'b0;
    start = 1'b0;
    step();
    checks++; if (state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", state, ST_IDLE); else passes++;
  endtask

  task automatic test_basic();
    int lat, cyc;
    clear_stats();
    ready_mode = 0;
    push_seq(3, 0);
    start_seq(3, 0);
    checks++; if (state !== ST_FETCH) $display("FAIL basic_fetch_state: got %0d expected %0d", state, ST_FETCH); else passes++;
    lat = 1;
    while (ctrl_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    checks++; if (lat !== 3) $display("FAIL basic_latency: got %0d expected 3", lat); else passes++;
    wait_done(100, cyc);
    checks++; if (cyc >= 100) $display("FAIL basic_timeout: got %0d cycles expected < 100", cyc); else passes++;
    checks++; if (ctrl_data !== '0 || ctrl_valid !== 1'b0) $display("FAIL basic_done_out: got %0h/%0b expected 0/0", ctrl_data, ctrl_valid); else passes++;
    repeat (3) step();
    checks++; if (done_cnt !== 1) $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); else passes++;
    checks++; if (valid_cycles !== 4) $display("FAIL basic_valid_cycles: got %0d expected 4", valid_cycles); else passes++;
    checks++; if (exp_q.size() != 0 || exp_addr_q.size() != 0) $display("FAIL basic_drain: got %0d/%0d left expected 0/0", exp_q.size(), exp_addr_q.size()); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %0b expected 0", busy); else passes++;
  endtask

  task automatic test_stall();
    int cyc;
    clear_stats();
    ready_mode = 1;
    push_seq(1, 2);
    start_seq(1, 2);
    wait_done(200, cyc);
    ready_mode = 0;
    checks++; if (cyc >= 200) $display("FAIL stall_timeout: got %0d cycles expected < 200", cyc); else passes++;
    repeat (2) step();
    checks++; if (beats !== 6) $display("FAIL stall_beats: got %0d expected 6", beats); else passes++;
    checks++; if (valid_cycles <= beats) $display("FAIL stall_seen: got %0d valid cycles expected > %0d", valid_cycles, beats); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL stall_done_cnt: got %0d expected 1", done_cnt); else passes++;
  endtask

  task automatic test_stop(input int hold, input string tag);
    int cyc;
    clear_stats();
    ready_mode = 0;
    push_seq((hold == 0) ? 1 : 2, hold);
    start_seq(5, hold);
    cyc = 0;
    while (!(ctrl_valid === 1'b1 && addrs === AW'((hold == 0) ? 1 : 2)) && cyc < 100) begin
      step();
      cyc++;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done(100, cyc);
    checks++; if (cyc >= 100) $display("FAIL %s_timeout: got %0d cycles expected < 100", tag, cyc); else passes++;
    repeat (4) step();
    checks++; if (done_cnt !== 1) $display("FAIL %s_done_cnt: got %0d expected 1", tag, done_cnt); else passes++;
    checks++; if (exp_q.size() != 0 || exp_addr_q.size() != 0) $display("FAIL %s_drain: got %0d/%0d left expected 0/0", tag, exp_q.size(), exp_addr_q.size()); else passes++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_stats();
    ready_mode = 0;
    push_seq(3, 3);
    start_seq(3, 3);
    cyc = 0;
    while (!(ctrl_valid === 1'b1 && addrs === AW'(1)) && cyc < 100) begin
      step();
      cyc++;
    end
    rst = 1'b1;
    start = 1'b1;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %0b expected 0", busy); else passes++;
    checks++; if (ctrl_valid !== 1'b0 || rd !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_ctrl: got %0b%0b%0b expected 000", ctrl_valid, rd, done); else passes++;
    checks++; if (ctrl_data !== '0 || addrs !== '0) $display("FAIL rstmid_data: got %0h/%0d expected 0/0", ctrl_data, addrs); else passes++;
    rst = 1'b0;
    start = 1'b0;
    step();
    checks++; if (state !== ST_IDLE) $display("FAIL rstmid_start_ignored: got %0d expected %0d", state, ST_IDLE); else passes++;
    exp_q.delete();
    exp_addr_q.delete();
    clear_stats();
    push_seq(0, 0);
    start_seq(0, 0);
    checks++; if (rd !== 1'b1 || addrs !== '0) $display("FAIL rstmid_restart: got rd %0b addr %0d expected 1/0", rd, addrs); else passes++;
    wait_done(50, cyc);
    repeat (2) step();
    checks++; if (done_cnt !== 1 || exp_q.size() != 0) $display("FAIL rstmid_rerun: got %0d done %0d left expected 1/0", done_cnt, exp_q.size()); else passes++;
  endtask

  task automatic test_busy_start();
    int cyc;
    clear_stats();
    ready_mode = 0;
    push_seq(0, 3);
    start_seq(0, 3);
    step();
    step();
    start = 1'b1;
    last_addrs = AW'(2);
    step();
    start = 1'b0;
    wait_done(50, cyc);
    repeat (5) step();
    checks++; if (done_cnt !== 1) $display("FAIL busystart_done_cnt: got %0d expected 1", done_cnt); else passes++;
    checks++; if (beats !== 4) $display("FAIL busystart_beats: got %0d expected 4", beats); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL busystart_idle: got %0b expected 0", busy); else passes++;
  endtask

  task automatic test_max_hold();
    int cyc;
    clear_stats();
    ready_mode = 0;
    push_seq(0, 255);
    start_seq(0, 255);
    wait_done(400, cyc);
    checks++; if (cyc >= 400) $display("FAIL maxhold_timeout: got %0d cycles expected < 400", cyc); else passes++;
    step();
    checks++; if (valid_cycles !== 256) $display("FAIL maxhold_beats: got %0d expected 256", valid_cycles); else passes++;
  endtask

  task automatic test_back_to_back();
    int cyc, last, hold;
    ready_mode = 2;
    for (int it = 0; it < 4; it++) begin
      clear_stats();
      last = $urandom_range(0, 3);
      hold = $urandom_range(0, 3);
      push_seq(last, hold);
      start_seq(last, hold);
      wait_done(300, cyc);
      checks++; if (cyc >= 300) $display("FAIL b2b_timeout: got %0d cycles expected < 300", cyc); else passes++;
      step();
      checks++; if (exp_q.size() != 0 || done_cnt !== 1) $display("FAIL b2b_drain: got %0d left %0d done expected 0/1", exp_q.size(), done_cnt); else passes++;
    end
    ready_mode = 0;
    step();
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    int cyc;
    clear_stats();
    ready_mode = 0;
    push_seq(2, 0);
    push_seq(1, 0);
    start_seq(2, 0);
    cyc = 0;
    while (!(ctrl_valid === 1'b1 && addrs === AW'(1) && valid_cycles >= 3) && cyc < 100) begin
      step();
      cyc++;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done(100, cyc);
    repeat (3) step();
    checks++; if (done_cnt !== 1) $display("FAIL loop_done_cnt: got %0d expected 1", done_cnt); else passes++;
    checks++; if (exp_q.size() != 0 || exp_addr_q.size() != 0) $display("FAIL loop_drain: got %0d/%0d left expected 0/0", exp_q.size(), exp_addr_q.size()); else passes++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = MW'({$urandom(), $urandom()}) | MW'(i + 1);
    test_reset();
    test_basic();
    test_stall();
    test_stop(1, "stop_mid");
    test_stop(0, "stop_final");
    test_reset_mid();
    test_busy_start();
    test_max_hold();
    test_back_to_back();
`ifdef SEQ_LOOP_EN
    test_loop();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
